// File: rtl/tape_pkg.sv
// Shared types, timing defaults and small helpers for the cassette record path.
package tape_pkg;

   typedef enum logic [1:0] {HUNT, DATA, PARITY, STOP} state_t;
   typedef enum logic [1:0] {BIT0, BIT1, GAP} bit_class_t;

   localparam int CLK_HZ_DEF     = 24_000_000;
   localparam int ONE_MAX_US_DEF = 312;
   localparam int GAP_US_DEF     = 1000;
   localparam int ADDR_W_DEF     = 16;
   localparam int PERIOD_W       = 10;

   localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

   // Odd parity: the data ones plus the parity bit must give an odd total.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/tape_recorder_if.sv
// Host-side signal bundle of the tape recorder: control inputs and tape cache write port.
interface tape_recorder_if
   import tape_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              arm;
   logic              motor;
   logic              tape_out;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic [ADDR_W:0]   tape_len;
   logic              rec_active;
   logic              overflow;
   logic [7:0]        parity_err;
   logic [7:0]        frame_err;

   modport master (
      output arm, motor, tape_out,
      input  wr_en, wr_addr, wr_data, tape_len, rec_active, overflow, parity_err, frame_err
   );

   modport slave (
      input  arm, motor, tape_out,
      output wr_en, wr_addr, wr_data, tape_len, rec_active, overflow, parity_err, frame_err
   );
endinterface

// File: rtl/tape_pulse_meter.sv
// Filters the tape signal, times rising-edge to rising-edge periods in microseconds and
// classifies each period as a '1' bit, a '0' bit or a gap.
module tape_pulse_meter
   import tape_pkg::*;
#(
   parameter int CLK_HZ     = CLK_HZ_DEF,
   parameter int ONE_MAX_US = ONE_MAX_US_DEF,
   parameter int GAP_US     = GAP_US_DEF
)(
   input  logic clk,
   input  logic reset_n,
   input  logic i_enable,
   input  logic i_tape,
   output logic o_bit_strobe,
   output logic o_bit_val,
   output logic o_gap_strobe
);
   localparam int DIV   = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DIV - 1);
   localparam logic [PERIOD_W-1:0] ONE_MAX  = PERIOD_W'(ONE_MAX_US);
   localparam logic [PERIOD_W-1:0] GAP_LIM  = PERIOD_W'(GAP_US);

   logic [PRE_W-1:0]    r_pre;
   logic                r_prev;
   logic                r_filt;
   logic                r_valid;
   logic [PERIOD_W-1:0] r_period;

   logic                w_tick;
   logic                w_rise;
   logic [PERIOD_W-1:0] w_period_inc;
   bit_class_t          w_class;

   assign w_tick       = (r_pre == PRE_LAST);
   // A new level is accepted once it has been seen on two consecutive cycles.
   assign w_rise       = i_tape & r_prev & ~r_filt;
   assign w_period_inc = (r_period == PERIOD_MAX) ? r_period : r_period + 1'b1;

   always_comb begin
      // NOTE: default first so every path assigns w_class and no latch is inferred.
      w_class = GAP;
      if (r_period < ONE_MAX)
         w_class = BIT1;
      else if (r_period < GAP_LIM)
         w_class = BIT0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pre        <= '0;
         r_prev       <= 1'b0;
         r_filt       <= 1'b0;
         r_valid      <= 1'b0;
         r_period     <= '0;
         o_bit_strobe <= 1'b0;
         o_bit_val    <= 1'b0;
         o_gap_strobe <= 1'b0;
      end else begin
         o_bit_strobe <= 1'b0;
         o_gap_strobe <= 1'b0;
         r_pre        <= w_tick ? '0 : r_pre + 1'b1;
         r_prev       <= i_tape;
         if (i_tape == r_prev)
            r_filt <= i_tape;

         if (!i_enable) begin
            r_valid  <= 1'b0;
            r_period <= '0;
         end else if (w_rise) begin
            // The first edge after an invalid period only starts the measurement.
            r_valid  <= 1'b1;
            r_period <= '0;
            if (r_valid) begin
               o_bit_strobe <= (w_class != GAP);
               o_bit_val    <= (w_class == BIT1);
               o_gap_strobe <= (w_class == GAP);
            end
         end else if (w_tick) begin
            r_period <= w_period_inc;
            if (r_valid && w_period_inc >= GAP_LIM) begin
               r_valid      <= 1'b0;
               o_gap_strobe <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tape_recorder.sv
// Record side of the cassette path: frames decoded tape bits into bytes and writes them
// sequentially into the tape cache, tracking length, overflow and error counts.
module tape_recorder
   import tape_pkg::*;
#(
   parameter int CLK_HZ     = CLK_HZ_DEF,
   parameter int ONE_MAX_US = ONE_MAX_US_DEF,
   parameter int GAP_US     = GAP_US_DEF,
   parameter int ADDR_W     = ADDR_W_DEF
)(
   input  logic           clk,
   input  logic           reset_n,
   tape_recorder_if.slave bus
);
   logic w_bit_strobe;
   logic w_bit_val;
   logic w_gap_strobe;
   logic w_arm_rise;
   logic w_commit;

   state_t            r_state;
   logic [7:0]        r_shift;
   logic [2:0]        r_cnt;
   logic              r_arm_d;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [7:0]        r_wr_data;
   logic [ADDR_W:0]   r_tape_len;
   logic              r_rec_active;
   logic              r_overflow;
   logic [7:0]        r_parity_err;
   logic [7:0]        r_frame_err;

   tape_pulse_meter #(
      .CLK_HZ     (CLK_HZ),
      .ONE_MAX_US (ONE_MAX_US),
      .GAP_US     (GAP_US)
   ) u_meter (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_enable     (bus.motor),
      .i_tape       (bus.tape_out),
      .o_bit_strobe (w_bit_strobe),
      .o_bit_val    (w_bit_val),
      .o_gap_strobe (w_gap_strobe)
   );

   assign w_arm_rise = bus.arm & ~r_arm_d;
   assign w_commit   = bus.motor & w_bit_strobe & w_bit_val & (r_state == STOP);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= HUNT;
         r_shift      <= '0;
         r_cnt        <= '0;
         r_arm_d      <= 1'b0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_tape_len   <= '0;
         r_rec_active <= 1'b0;
         r_overflow   <= 1'b0;
         r_parity_err <= '0;
         r_frame_err  <= '0;
      end else begin
         r_arm_d      <= bus.arm;
         r_wr_en      <= 1'b0;
         r_rec_active <= bus.motor & ~r_overflow;

         if (!bus.motor || w_gap_strobe) begin
            r_state <= HUNT;
         end else if (w_bit_strobe) begin
            unique case (r_state)
               HUNT: begin
                  if (!w_bit_val) begin
                     r_state <= DATA;
                     r_cnt   <= '0;
                  end
               end
               DATA: begin
                  r_shift <= {w_bit_val, r_shift[7:1]};
                  r_cnt   <= r_cnt + 1'b1;
                  if (r_cnt == 3'd7)
                     r_state <= PARITY;
               end
               PARITY: begin
                  if (!odd_parity_ok(r_shift, w_bit_val))
                     r_parity_err <= sat_inc(r_parity_err);
                  r_state <= STOP;
               end
               STOP: begin
                  if (!w_bit_val)
                     r_frame_err <= sat_inc(r_frame_err);
                  r_state <= HUNT;
               end
               default: r_state <= HUNT;
            endcase
         end

         // Arm is evaluated last so it overrides a commit or count update in the same cycle.
         if (w_arm_rise) begin
            r_tape_len   <= '0;
            r_overflow   <= 1'b0;
            r_parity_err <= '0;
            r_frame_err  <= '0;
         end else if (w_commit && !r_overflow) begin
            r_wr_en    <= 1'b1;
            r_wr_addr  <= r_tape_len[ADDR_W-1:0];
            r_wr_data  <= r_shift;
            r_tape_len <= r_tape_len + 1'b1;
            if (&r_tape_len[ADDR_W-1:0])
               r_overflow <= 1'b1;
         end
      end
   end

   assign bus.wr_en      = r_wr_en;
   assign bus.wr_addr    = r_wr_addr;
   assign bus.wr_data    = r_wr_data;
   assign bus.tape_len   = r_tape_len;
   assign bus.rec_active = r_rec_active;
   assign bus.overflow   = r_overflow;
   assign bus.parity_err = r_parity_err;
   assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_tape_recorder.sv
// Directed bench for tape_recorder: a 16-bit-address and a 4-bit-address instance share one
// tape stream. Timing is scaled (2 MHz clock, 26 us '1' cells, 52 us '0' cells) to keep runs short.
module tb_tape_recorder;

   localparam int CLK_HZ     = 2_000_000;
   localparam int ONE_MAX_US = 39;
   localparam int GAP_US     = 125;
   localparam int T1         = 52;    // clock cycles per '1' cell
   localparam int T0         = 104;   // clock cycles per '0' cell

   logic clk;
   logic reset_n;
   logic arm;
   logic motor;
   logic tape_out;

   int total = 0;
   int bad   = 0;

   int          n_wr16 = 0;
   int          n_wr4  = 0;
   int          n_wide = 0;
   logic        prev_wr16 = 1'b0;
   logic        prev_wr4  = 1'b0;
   logic [15:0] last_addr16 = '0;
   logic [7:0]  last_data16 = '0;
   logic [3:0]  last_addr4  = '0;
   logic [7:0]  last_data4  = '0;
   int          base16;
   int          base4;

   tape_recorder_if #(.ADDR_W(16)) b16 ();
   tape_recorder_if #(.ADDR_W(4))  b4 ();

   assign b16.arm      = arm;
   assign b16.motor    = motor;
   assign b16.tape_out = tape_out;
   assign b4.arm       = arm;
   assign b4.motor     = motor;
   assign b4.tape_out  = tape_out;

   tape_recorder #(
      .CLK_HZ (CLK_HZ), .ONE_MAX_US (ONE_MAX_US), .GAP_US (GAP_US), .ADDR_W (16)
   ) dut16 (
      .clk (clk), .reset_n (reset_n), .bus (b16.slave)
   );

   tape_recorder #(
      .CLK_HZ (CLK_HZ), .ONE_MAX_US (ONE_MAX_US), .GAP_US (GAP_US), .ADDR_W (4)
   ) dut4 (
      .clk (clk), .reset_n (reset_n), .bus (b4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write-port monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (b16.wr_en) begin
         n_wr16++;
         last_addr16 = b16.wr_addr;
         last_data16 = b16.wr_data;
      end
      if (b4.wr_en) begin
         n_wr4++;
         last_addr4 = b4.wr_addr;
         last_data4 = b4.wr_data;
      end
      if ((b16.wr_en && prev_wr16) || (b4.wr_en && prev_wr4))
         n_wide++;
      prev_wr16 = b16.wr_en;
      prev_wr4  = b4.wr_en;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One bit cell: low, then a rising edge that closes the period.
   task automatic send_bit(input logic b);
      int n;
      n = b ? T1 : T0;
      @(negedge clk) tape_out = 1'b0;
      cycles(n - 8);
      tape_out = 1'b1;
      cycles(8);
   endtask

   task automatic lead_edge();
      @(negedge clk) tape_out = 1'b0;
      cycles(8);
      tape_out = 1'b1;
      cycles(8);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic par_good, input logic stop);
      send_bit(1'b0);
      for (int k = 0; k < 8; k++)
         send_bit(d[k]);
      send_bit(par_good ? ~^d : ^d);
      send_bit(stop);
   endtask

   task automatic pulse_arm();
      @(negedge clk) arm = 1'b1;
      cycles(2);
      arm = 1'b0;
      cycles(2);
   endtask

   initial begin
      reset_n  = 1'b0;
      arm      = 1'b0;
      motor    = 1'b0;
      tape_out = 1'b0;
      cycles(5);
      reset_n = 1'b1;

      // Reset asserted in the middle of a byte
      motor = 1'b1;
      cycles(4);
      lead_edge();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      @(negedge clk) reset_n = 1'b0;
      cycles(2);
      check("rst_wr_en",      32'(b16.wr_en), 0);
      check("rst_tape_len",   32'(b16.tape_len), 0);
      check("rst_rec_active", 32'(b16.rec_active), 0);
      check("rst_overflow",   32'(b16.overflow), 0);
      check("rst_parity_err", 32'(b16.parity_err), 0);
      check("rst_frame_err",  32'(b16.frame_err), 0);
      check("rst_wr_addr",    32'(b16.wr_addr), 0);
      check("rst_wr_data",    32'(b16.wr_data), 0);
      @(negedge clk) reset_n = 1'b1;
      base16 = n_wr16;
      cycles(600);
      check("idle_no_write",  32'(n_wr16 - base16), 0);
      check("idle_rec_active", 32'(b16.rec_active), 1);

      // Good byte 0x16
      pulse_arm();
      base16 = n_wr16;
      lead_edge();
      send_byte(8'h16, 1'b1, 1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      check("b16_writes",   32'(n_wr16 - base16), 1);
      check("b16_data",     32'(last_data16), 32'h16);
      check("b16_addr",     32'(last_addr16), 0);
      check("b16_len",      32'(b16.tape_len), 1);
      check("b16_par_err",  32'(b16.parity_err), 0);

      // 0x24 with a wrong parity bit is still written
      base16 = n_wr16;
      send_byte(8'h24, 1'b0, 1'b1);
      send_bit(1'b1);
      check("b24_writes",  32'(n_wr16 - base16), 1);
      check("b24_data",    32'(last_data16), 32'h24);
      check("b24_addr",    32'(last_addr16), 1);
      check("b24_par_err", 32'(b16.parity_err), 1);
      check("b24_len",     32'(b16.tape_len), 2);

      // 0xAA with a 0 stop bit is dropped; the next byte lands at the current length
      base16 = n_wr16;
      send_byte(8'hAA, 1'b1, 1'b0);
      send_bit(1'b1);
      check("baa_no_write",  32'(n_wr16 - base16), 0);
      check("baa_frame_err", 32'(b16.frame_err), 1);
      send_byte(8'h16, 1'b1, 1'b1);
      send_bit(1'b1);
      check("after_fe_writes", 32'(n_wr16 - base16), 1);
      check("after_fe_addr",   32'(last_addr16), 2);
      check("after_fe_len",    32'(b16.tape_len), 3);

      // Motor dropped after four data bits
      base16 = n_wr16;
      send_bit(1'b0);
      for (int k = 0; k < 4; k++)
         send_bit(1'b1);
      @(negedge clk) motor = 1'b0;
      cycles(20);
      check("motor_off_active", 32'(b16.rec_active), 0);
      motor = 1'b1;
      cycles(4);
      lead_edge();
      send_byte(8'h55, 1'b1, 1'b1);
      send_bit(1'b1);
      check("motor_writes", 32'(n_wr16 - base16), 1);
      check("motor_data",   32'(last_data16), 32'h55);
      check("motor_addr",   32'(last_addr16), 3);
      check("motor_len",    32'(b16.tape_len), 4);

      // Gap of 1.5x the gap threshold in the middle of a byte
      base16 = n_wr16;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      @(negedge clk) tape_out = 1'b0;
      cycles(380);
      check("gap_no_write", 32'(n_wr16 - base16), 0);
      check("gap_len",      32'(b16.tape_len), 4);
      lead_edge();
      send_byte(8'h16, 1'b1, 1'b1);
      send_bit(1'b1);
      check("gap_resync_writes", 32'(n_wr16 - base16), 1);
      check("gap_resync_addr",   32'(last_addr16), 4);
      check("gap_errs_unchanged", 32'(b16.frame_err), 1);

      // Fill the 16-entry cache with 17 bytes
      pulse_arm();
      check("arm_len16",     32'(b16.tape_len), 0);
      check("arm_par_err16", 32'(b16.parity_err), 0);
      check("arm_frm_err16", 32'(b16.frame_err), 0);
      base16 = n_wr16;
      base4  = n_wr4;
      for (int i = 0; i < 17; i++) begin
         logic [7:0] d;
         d = 8'(i);
         send_byte(d, 1'b1, 1'b1);
         send_bit(1'b1);
      end
      check("full_writes4",  32'(n_wr4 - base4), 16);
      check("full_overflow", 32'(b4.overflow), 1);
      check("full_len4",     32'(b4.tape_len), 16);
      check("full_last_addr4", 32'(last_addr4), 15);
      check("full_last_data4", 32'(last_data4), 32'h0F);
      check("full_rec_active", 32'(b4.rec_active), 0);
      check("full_writes16", 32'(n_wr16 - base16), 17);
      check("full_len16",    32'(b16.tape_len), 17);
      check("full_ovf16",    32'(b16.overflow), 0);
      pulse_arm();
      check("rearm_overflow", 32'(b4.overflow), 0);
      check("rearm_len4",     32'(b4.tape_len), 0);
      check("rearm_active",   32'(b4.rec_active), 1);

      check("wr_en_width", 32'(n_wide), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
